// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file writeback path.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  // Register 0 is hardwired to zero; writes to it are discarded.
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } reg_wr_t;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin grant: the search starts at ptr and wraps N-1 -> 0.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  int   idx;
  logic found;

  // First valid request at or after ptr (modulo N) wins; one-hot result.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between NREQ writeback sources.
// Handshake: a requester holds valid/addr/data stable until it sees ready; a
// transfer happens on a rising edge where valid & ready are both high, and at
// most one ready bit is set per cycle. Accepted writes appear on we3/a3/wd3 one
// cycle later; writes to register 0 are accepted but never reach the port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   we3,
  output logic [ADDR_W-1:0]      a3,
  output logic [DATA_W-1:0]      wd3,
  output logic                   collision
);

  localparam int PTR_W = idx_width(NREQ);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              coll_q, coll_d;

  logic [NREQ-1:0]   gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(.N(NREQ), .PTR_W(PTR_W)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Nobody is accepted while reset is held, so no request is silently consumed.
  assign req_ready = rstn ? gnt : '0;
  assign xfer      = |req_ready;

  // Select the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pointer moves past the winner on a transfer, otherwise holds.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // Output stage: register 0 writes are swallowed without touching a3/wd3.
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (xfer && (sel_addr != ADDR_W'(REG_ZERO))) begin
      we3_d = 1'b1;
      a3_d  = sel_addr;
      wd3_d = sel_data;
    end
  end

  // Flag two or more valid requesters aiming at the same nonzero register.
  always_comb begin
    coll_d = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (req_valid[i] && req_valid[j] &&
            (req_addr[i*ADDR_W +: ADDR_W] == req_addr[j*ADDR_W +: ADDR_W]) &&
            (req_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
          coll_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      coll_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      coll_q   <= coll_d;
    end
  end

  assign we3       = we3_q;
  assign a3        = a3_q;
  assign wd3       = wd3_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a register-file model on the write port.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               we3;
  logic [AW-1:0]      a3;
  logic [DW-1:0]      wd3;
  logic               collision;

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .collision (collision)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- register file model ----------------
  logic [DW-1:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (we3) rf[a3] <= wd3;

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic [NREQ-1:0]  pend_q = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Every write seen on the port must be the next expected one.
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'b0, a3}, 32'hFFFF_FFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("sb_addr", {27'b0, a3}, {27'b0, e[AW+DW-1:DW]});
        chk("sb_data", wd3, e[DW-1:0]);
      end
    end
  end

  // Requester obligation: a pending request must stay valid until ready.
  always @(negedge clk) begin
    chk("valid_hold", {30'b0, req_valid & pend_q}, {30'b0, pend_q});
    pend_q <= req_valid & ~req_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]       = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic chk_port(input string tag, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, "_we3"}, {31'b0, we3}, {31'b0, w});
    chk({tag, "_a3"}, {27'b0, a3}, {27'b0, a});
    chk({tag, "_wd3"}, wd3, d);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    cyc();
    cyc();
    #1;
    chk_port("reset", 1'b0, 5'd0, 32'h0);
    chk("reset_coll", {31'b0, collision}, 32'h0);
    chk("reset_ready", {30'b0, req_ready}, 32'h0);

    // Single requester: ready same cycle, port next cycle, readback at N+2.
    cyc();
    rstn = 1'b1;
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    push(5'd5, 32'hDEAD_BEEF);
    #1 chk("t1_ready", {30'b0, req_ready}, 32'h1);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1 chk_port("t1_out", 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("t1_ready_idle", {30'b0, req_ready}, 32'h0);
    cyc();
    #1 chk_port("t1_after", 1'b0, 5'd5, 32'hDEAD_BEEF);
    chk("t1_rd5", rf[5], 32'hDEAD_BEEF);

    // Register 0: accepted, discarded, port holds. Pointer is 1 here.
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1 chk("t3_ready", {30'b0, req_ready}, 32'h2);
    cyc();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1 chk_port("t3_out", 1'b0, 5'd5, 32'hDEAD_BEEF);
    cyc();
    #1 chk("t3_rd0", rf[0], 32'h0);

    // Contention from pointer 0: grants alternate 0,1,0,1.
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    push(5'd1, 32'h11);
    #1 chk("t2_g0", {30'b0, req_ready}, 32'h1);
    cyc();
    set_req(0, 1'b1, 5'd3, 32'h33);
    push(5'd2, 32'h22);
    #1 chk("t2_g1", {30'b0, req_ready}, 32'h2);
    chk_port("t2_w0", 1'b1, 5'd1, 32'h11);
    cyc();
    set_req(1, 1'b1, 5'd4, 32'h44);
    push(5'd3, 32'h33);
    #1 chk("t2_g2", {30'b0, req_ready}, 32'h1);
    chk_port("t2_w1", 1'b1, 5'd2, 32'h22);
    cyc();
    set_req(0, 1'b1, 5'd6, 32'h66);
    push(5'd4, 32'h44);
    #1 chk("t2_g3", {30'b0, req_ready}, 32'h2);
    chk_port("t2_w2", 1'b1, 5'd3, 32'h33);
    cyc();
    set_req(1, 1'b0, 5'd0, 32'h0);
    push(5'd6, 32'h66);
    #1 chk("t2_g4", {30'b0, req_ready}, 32'h1);
    chk_port("t2_w3", 1'b1, 5'd4, 32'h44);
    chk("t2_coll", {31'b0, collision}, 32'h0);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1 chk_port("t2_w4", 1'b1, 5'd6, 32'h66);

    // Bring the pointer back to 0 with a discarded write from requester 1.
    set_req(1, 1'b1, 5'd0, 32'h0);
    #1 chk("ptr_fix_ready", {30'b0, req_ready}, 32'h2);
    cyc();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1 chk("t2_rd1", rf[1], 32'h11);
    chk("t2_rd4", rf[4], 32'h44);
    chk("t2_rd6", rf[6], 32'h66);

    // Collision on register 7: one-cycle pulse, later grant wins.
    set_req(0, 1'b1, 5'd7, 32'hA);
    set_req(1, 1'b1, 5'd7, 32'hB);
    push(5'd7, 32'hA);
    #1 chk("t4_ready0", {30'b0, req_ready}, 32'h1);
    chk("t4_coll_pre", {31'b0, collision}, 32'h0);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'h0);
    push(5'd7, 32'hB);
    #1 chk("t4_coll", {31'b0, collision}, 32'h1);
    chk("t4_ready1", {30'b0, req_ready}, 32'h2);
    chk_port("t4_wA", 1'b1, 5'd7, 32'hA);
    cyc();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1 chk("t4_coll_end", {31'b0, collision}, 32'h0);
    chk_port("t4_wB", 1'b1, 5'd7, 32'hB);
    cyc();
    #1 chk("t4_rd7", rf[7], 32'hB);

    // Back-to-back: eight writes from requester 0 with valid held high.
    for (int k = 1; k <= 8; k++) begin
      set_req(0, 1'b1, AW'(k), 32'h1000 + 32'(k));
      push(AW'(k), 32'h1000 + 32'(k));
      #1 chk("t6_ready", {30'b0, req_ready}, 32'h1);
      if (k > 1) chk_port("t6_w", 1'b1, AW'(k - 1), 32'h1000 + 32'(k - 1));
      cyc();
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1 chk_port("t6_last", 1'b1, 5'd8, 32'h1008);
    cyc();
    for (int k = 1; k <= 8; k++) chk("t6_rd", rf[k], 32'h1000 + 32'(k));

    // Reset mid-operation: pointer is 1 after this accept, reset returns it to 0.
    set_req(0, 1'b1, 5'd3, 32'h333);
    push(5'd3, 32'h333);
    #1 chk("t5_acc", {30'b0, req_ready}, 32'h1);
    cyc();
    set_req(0, 1'b1, 5'd10, 32'hAA);
    set_req(1, 1'b1, 5'd11, 32'hBB);
    rstn = 1'b0;
    #1 chk("t5_ready_rst", {30'b0, req_ready}, 32'h0);
    chk("t5_we3_pre", {31'b0, we3}, 32'h1);
    cyc();
    #1 chk_port("t5_rst", 1'b0, 5'd0, 32'h0);
    chk("t5_coll_rst", {31'b0, collision}, 32'h0);
    chk("t5_ready_rst2", {30'b0, req_ready}, 32'h0);
    cyc();
    rstn = 1'b1;
    push(5'd10, 32'hAA);
    #1 chk("t5_restart", {30'b0, req_ready}, 32'h1);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'h0);
    push(5'd11, 32'hBB);
    #1 chk("t5_next", {30'b0, req_ready}, 32'h2);
    chk_port("t5_w10", 1'b1, 5'd10, 32'hAA);
    cyc();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1 chk_port("t5_w11", 1'b1, 5'd11, 32'hBB);
    cyc();
    cyc();
    chk("sb_drained", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
